// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch stage controller: PC, IF/ID register, stalls, delayed branches
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   IF_loadUseStall     hold PC and IF/ID this cycle (hazard detector)
//   IF_memConflict      MEM stage owns instruction memory; inject a bubble
//   IF_branchTaken      ID-stage branch resolved taken (one delay slot)
//   IF_branchTarget     redirect address, valid with IF_branchTaken
//   IF_instrIn          instruction memory data for IF_pc, same cycle
//   IF_pc               PC register / instruction memory address
//   IF_imemRead         instruction memory read enable (combinational)
//   IF_ID_instruction   IF/ID instruction register
//   IF_ID_pcPlus1       IF/ID fetch address + 1
//   IF_ID_valid         IF/ID holds a real instruction (0 = bubble)
//   IF_stallCount       saturating count of stall cycles since reset
module if_fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_loadUseStall,
  input  logic        IF_memConflict,
  input  logic        IF_branchTaken,
  input  logic [15:0] IF_branchTarget,
  input  logic [15:0] IF_instrIn,
  output logic [15:0] IF_pc,
  output logic        IF_imemRead,
  output logic [15:0] IF_ID_instruction,
  output logic [15:0] IF_ID_pcPlus1,
  output logic        IF_ID_valid,
  output logic [15:0] IF_stallCount
);

  // PEND: a taken branch's delay slot has not been fetched yet; r_tgt holds the target.
  typedef enum logic {ST_RUN, ST_PEND} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_tgt;
  logic [15:0] r_instr;
  logic [15:0] r_pcp1;
  logic        r_valid;
  logic [15:0] r_stall_cnt;

  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_tgt_nxt;
  logic [15:0] w_instr_nxt;
  logic [15:0] w_pcp1_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_pc_plus1;
  logic        w_stall;

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_stall    = IF_loadUseStall || IF_memConflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_tgt       <= 16'h0000;
      r_instr     <= NOP_INSTR;
      r_pcp1      <= 16'h0000;
      r_valid     <= 1'b0;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_instr <= w_instr_nxt;
      r_pcp1  <= w_pcp1_nxt;
      r_valid <= w_valid_nxt;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_instr_nxt = r_instr;
    w_pcp1_nxt  = r_pcp1;
    w_valid_nxt = r_valid;
    if (IF_loadUseStall) begin
      // Everything holds; a branch decision from a stalled ID stage is not final.
    end else if (IF_memConflict) begin
      // Bubble into ID; pcPlus1 is left alone. A branch resolved now still
      // owes its delay slot, so remember the target until the fetch succeeds.
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      if ((r_state == ST_RUN) && IF_branchTaken) begin
        w_tgt_nxt   = IF_branchTarget;
        w_state_nxt = ST_PEND;
      end
    end else begin
      w_instr_nxt = IF_instrIn;
      w_pcp1_nxt  = w_pc_plus1;
      w_valid_nxt = 1'b1;
      if (r_state == ST_PEND) begin
        w_pc_nxt    = r_tgt;
        w_state_nxt = ST_RUN;
      end else begin
        w_pc_nxt = IF_branchTaken ? IF_branchTarget : w_pc_plus1;
      end
    end
  end

  assign IF_pc             = r_pc;
  assign IF_imemRead       = !rst && !IF_memConflict;
  assign IF_ID_instruction = r_instr;
  assign IF_ID_pcPlus1     = r_pcp1;
  assign IF_ID_valid       = r_valid;
  assign IF_stallCount     = r_stall_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard testbench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lus;
  logic        mc;
  logic        bt;
  logic [15:0] tgt;
  logic [15:0] instr_in;
  logic [15:0] pc;
  logic        imem_rd;
  logic [15:0] id_instr;
  logic [15:0] id_pcp1;
  logic        id_valid;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rst;
    logic        lus;
    logic        mc;
    logic        bt;
    logic [15:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp1;
    logic        valid;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Instruction memory model: mem[i] = 16'h1000 + i
  assign instr_in = 16'h1000 + pc;

  if_fetch_ctrl #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_loadUseStall   (lus),
    .IF_memConflict    (mc),
    .IF_branchTaken    (bt),
    .IF_branchTarget   (tgt),
    .IF_instrIn        (instr_in),
    .IF_pc             (pc),
    .IF_imemRead       (imem_rd),
    .IF_ID_instruction (id_instr),
    .IF_ID_pcPlus1     (id_pcp1),
    .IF_ID_valid       (id_valid),
    .IF_stallCount     (stall_cnt)
  );

  function automatic stim_t S(logic r, logic l, logic m, logic b, logic [15:0] t);
    S = {r, l, m, b, t};
  endfunction

  function automatic exp_t E(logic [15:0] i, logic [15:0] p1, logic v, logic [15:0] p);
    E = {i, p1, v, p};
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; lus = s.lus; mc = s.mc; bt = s.bt; tgt = s.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(S(1, 0, 0, 0, 16'h0));
    n_checks++;
    if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_imemRead got %h exp 0", imem_rd); end
    n_checks++;
    if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", pc); end
    n_checks++;
    if (id_instr !== 16'h0800) begin n_fail++; $display("FAIL reset_instr got %h exp 0800", id_instr); end
    n_checks++;
    if (id_pcp1 !== 16'h0000) begin n_fail++; $display("FAIL reset_pcp1 got %h exp 0000", id_pcp1); end
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", id_valid); end
    n_checks++;
    if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", stall_cnt); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_rd !== 1'b1) begin n_fail++; $display("FAIL run_imemRead got %h exp 1", imem_rd); end
  endtask

  task automatic test_free_run;
    stim_t st[$];
    exp_t  e;
    st = '{S(0,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
    sb.push_back(E(16'h1000, 16'h0001, 1, 16'h0001));
    sb.push_back(E(16'h1001, 16'h0002, 1, 16'h0002));
    sb.push_back(E(16'h1002, 16'h0003, 1, 16'h0003));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL free_run step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
    end
  endtask

  task automatic test_load_use;
    stim_t st[$];
    exp_t  e;
    st = '{S(0,0,0,0,0), S(0,0,0,0,0), S(0,1,0,1,16'h0040), S(0,0,0,0,0)};
    sb.push_back(E(16'h1003, 16'h0004, 1, 16'h0004));
    sb.push_back(E(16'h1004, 16'h0005, 1, 16'h0005));
    sb.push_back(E(16'h1004, 16'h0005, 1, 16'h0005));
    sb.push_back(E(16'h1005, 16'h0006, 1, 16'h0006));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL load_use step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
    end
    n_checks++;
    if (stall_cnt !== 16'h0001) begin n_fail++; $display("FAIL load_use_cnt got %h exp 0001", stall_cnt); end
  endtask

  task automatic test_branch;
    stim_t st[$];
    exp_t  e;
    st = '{S(0,0,0,0,0), S(0,0,0,0,0), S(0,0,0,1,16'h0040), S(0,0,0,0,0)};
    sb.push_back(E(16'h1006, 16'h0007, 1, 16'h0007));
    sb.push_back(E(16'h1007, 16'h0008, 1, 16'h0008));
    sb.push_back(E(16'h1008, 16'h0009, 1, 16'h0040));
    sb.push_back(E(16'h1040, 16'h0041, 1, 16'h0041));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL branch step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
    end
  endtask

  task automatic test_branch_conflict;
    stim_t st[$];
    exp_t  e;
    apply(S(1, 0, 0, 0, 0));
    // Reach PC=8 via a branch, then resolve a branch to 0040 under two conflict cycles.
    st = '{S(0,0,0,1,16'h0008), S(0,0,1,1,16'h0040), S(0,0,1,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
    sb.push_back(E(16'h1000, 16'h0001, 1, 16'h0008));
    sb.push_back(E(16'h0800, 16'h0001, 0, 16'h0008));
    sb.push_back(E(16'h0800, 16'h0001, 0, 16'h0008));
    sb.push_back(E(16'h1008, 16'h0009, 1, 16'h0040));
    sb.push_back(E(16'h1040, 16'h0041, 1, 16'h0041));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL branch_conflict step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
    end
    n_checks++;
    if (stall_cnt !== 16'h0002) begin n_fail++; $display("FAIL branch_conflict_cnt got %h exp 0002", stall_cnt); end
    mc = 1'b1;
    #1;
    n_checks++;
    if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL conflict_imemRead got %h exp 0", imem_rd); end
    mc = 1'b0;
  endtask

  task automatic test_wrap;
    stim_t st[$];
    exp_t  e;
    st = '{S(0,0,0,1,16'hFFFF), S(0,0,0,0,0)};
    sb.push_back(E(16'h1041, 16'h0042, 1, 16'hFFFF));
    sb.push_back(E(16'h0FFF, 16'h0000, 1, 16'h0000));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL wrap step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
    end
  endtask

  task automatic test_reset_in_pend;
    stim_t st[$];
    exp_t  e;
    // Enter PEND with target 0040, hold it through a load-use stall, then reset.
    st = '{S(0,0,1,1,16'h0040), S(0,1,0,0,0), S(1,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
    sb.push_back(E(16'h0800, 16'h0000, 0, 16'h0000));
    sb.push_back(E(16'h0800, 16'h0000, 0, 16'h0000));
    sb.push_back(E(16'h0800, 16'h0000, 0, 16'h0000));
    sb.push_back(E(16'h1000, 16'h0001, 1, 16'h0001));
    sb.push_back(E(16'h1001, 16'h0002, 1, 16'h0002));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      e = sb.pop_front();
      n_checks++;
      if ({id_instr, id_pcp1, id_valid, pc} !== e)
        begin n_fail++; $display("FAIL reset_in_pend step %0d got %h/%h/%b/%h exp %h/%h/%b/%h", i, id_instr, id_pcp1, id_valid, pc, e.instr, e.pcp1, e.valid, e.pc); end
      if (i == 2) begin
        n_checks++;
        if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_in_pend_cnt got %h exp 0000", stall_cnt); end
      end
    end
  endtask

  task automatic test_saturation;
    apply(S(1, 0, 0, 0, 0));
    rst = 1'b0; lus = 1'b1; mc = 1'b0; bt = 1'b0;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    n_checks++;
    if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h exp fffe", stall_cnt); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat got %h exp ffff", stall_cnt); end
    n_checks++;
    if (pc !== 16'h0000) begin n_fail++; $display("FAIL sat_pc_hold got %h exp 0000", pc); end
    lus = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lus = 1'b0; mc = 1'b0; bt = 1'b0; tgt = 16'h0;
    @(negedge clk);
    test_reset;
    test_free_run;
    test_load_use;
    test_branch;
    test_branch_conflict;
    test_wrap;
    test_reset_in_pend;
    test_saturation;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
